// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb game controller.
//   state_t        : game state encoding, also driven out on state_o
//   WIRE_COUNT     : number of cuttable wires
//   DIGIT_EXPIRED  : value both timer digits show when the countdown ran out
//   sat_inc        : 2-bit saturating increment used for the strike counter
package bomb_pkg;

    localparam int         WIRE_COUNT    = 4;
    localparam logic [3:0] DIGIT_EXPIRED = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM_ERR  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_DEFUSED  = 3'd3,
        ST_EXPLODED = 3'd4
    } state_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

endpackage

// File: rtl/bomb_blink.sv
// Square-wave generator for the led and buzzer indicators.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : restart the waveform (counter to 0, output to 1)
//   blink    : output, holds each level for BLINK_DIV cycles
module bomb_blink #(
    parameter int BLINK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic blink
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (clear) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            blink <= ~blink;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb defusal game controller.
//   clk, rst            : clock, asynchronous active-low reset
//   btn_arm             : arm request level (rising edge acts)
//   wire_cut[3:0]       : wire levels, 1 = cut
//   tmr_s1, tmr_s2      : countdown digits from the timer, F/F = expired
//   tmr_start           : high while ARMED, lets the timer count
//   tmr_success         : high while DEFUSED
//   frz_s1, frz_s2      : timer digits captured when the game ended
//   state_o             : current state encoding
//   strikes             : wrong cuts this game
//   led, buzzer         : defused / detonation (and arm error) indicators
module bomb_game_ctrl
    import bomb_pkg::*;
#(
    parameter int DEFUSE_WIRE = 2,
    parameter int STRIKES_MAX = 2,
    parameter int BLINK_DIV   = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_arm,
    input  logic [3:0] wire_cut,
    input  logic [3:0] tmr_s1,
    input  logic [3:0] tmr_s2,
    output logic       tmr_start,
    output logic       tmr_success,
    output logic [3:0] frz_s1,
    output logic [3:0] frz_s2,
    output logic [2:0] state_o,
    output logic [1:0] strikes,
    output logic       led,
    output logic       buzzer
);

    localparam logic [WIRE_COUNT-1:0] DEFUSE_MASK = WIRE_COUNT'(1) << DEFUSE_WIRE;

    state_t                state, state_next;
    logic                  arm_q;
    logic [WIRE_COUNT-1:0] cut_q;
    logic [1:0]            strikes_next, strike_inc;
    logic [3:0]            frz_s1_next, frz_s2_next;
    logic                  blink;

    // Edges compare the live input against last cycle's sample. The edge
    // registers clear in reset, but the state also returns to IDLE, where
    // wire edges are never looked at, so wires cut across reset are harmless.
    logic                  arm_edge;
    logic [WIRE_COUNT-1:0] cut_edge;
    logic                  defuse_edge, wrong_edge, expired;

    assign arm_edge    = btn_arm & ~arm_q;
    assign cut_edge    = wire_cut & ~cut_q;
    assign defuse_edge = |(cut_edge & DEFUSE_MASK);
    assign wrong_edge  = |(cut_edge & ~DEFUSE_MASK);
    assign expired     = (tmr_s1 == DIGIT_EXPIRED) && (tmr_s2 == DIGIT_EXPIRED);
    assign strike_inc  = sat_inc(strikes);

    // State register plus the game datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            arm_q   <= 1'b0;
            cut_q   <= '0;
            strikes <= 2'd0;
            frz_s1  <= 4'd0;
            frz_s2  <= 4'd0;
        end else begin
            state   <= state_next;
            arm_q   <= btn_arm;
            cut_q   <= wire_cut;
            strikes <= strikes_next;
            frz_s1  <= frz_s1_next;
            frz_s2  <= frz_s2_next;
        end
    end

    // Next-state logic. In ARMED the order is expiry, strikes, then defuse,
    // so a wrong cut that detonates wins over a simultaneous correct cut.
    always_comb begin
        state_next   = state;
        strikes_next = strikes;
        frz_s1_next  = frz_s1;
        frz_s2_next  = frz_s2;
        case (state)
            ST_IDLE: begin
                if (arm_edge) begin
                    if (wire_cut == '0) begin
                        // New game: strike count and frozen digits start clean
                        state_next   = ST_ARMED;
                        strikes_next = 2'd0;
                        frz_s1_next  = 4'd0;
                        frz_s2_next  = 4'd0;
                    end else begin
                        state_next = ST_ARM_ERR;
                    end
                end
            end
            ST_ARM_ERR: begin
                if (wire_cut == '0) state_next = ST_IDLE;
            end
            ST_ARMED: begin
                if (expired) begin
                    state_next  = ST_EXPLODED;
                    frz_s1_next = 4'd0;
                    frz_s2_next = 4'd0;
                end else if (wrong_edge) begin
                    strikes_next = strike_inc;
                    if (int'(strike_inc) >= STRIKES_MAX) begin
                        state_next  = ST_EXPLODED;
                        frz_s1_next = tmr_s1;
                        frz_s2_next = tmr_s2;
                    end else if (defuse_edge) begin
                        state_next  = ST_DEFUSED;
                        frz_s1_next = tmr_s1;
                        frz_s2_next = tmr_s2;
                    end
                end else if (defuse_edge) begin
                    state_next  = ST_DEFUSED;
                    frz_s1_next = tmr_s1;
                    frz_s2_next = tmr_s2;
                end
            end
            ST_DEFUSED, ST_EXPLODED: begin
                if (arm_edge) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic, decoded from the registered state
    always_comb begin
        tmr_start   = (state == ST_ARMED);
        tmr_success = (state == ST_DEFUSED);
        led         = (state == ST_DEFUSED) & blink;
        buzzer      = ((state == ST_EXPLODED) || (state == ST_ARM_ERR)) & blink;
        state_o     = state;
    end

    // One blink generator serves both indicators; it restarts on every state
    // change so each indicating state begins with the output high.
    bomb_blink #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk   (clk),
        .rst   (rst),
        .clear (state_next != state),
        .blink (blink)
    );

endmodule

// File: tb/tb_bomb_game_ctrl.sv
module tb_bomb_game_ctrl;
    import bomb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_arm;
    logic [3:0] wire_cut;
    logic [3:0] tmr_s1;
    logic [3:0] tmr_s2;
    logic       tmr_start;
    logic       tmr_success;
    logic [3:0] frz_s1;
    logic [3:0] frz_s2;
    logic [2:0] state_o;
    logic [1:0] strikes;
    logic       led;
    logic       buzzer;

    int total = 0;
    int bad   = 0;

    // Expected output snapshot: {state, start, success, frz_s1, frz_s2, strikes, led, buzzer}
    logic [16:0] exp_q[$];
    string       name_q[$];
    logic [16:0] act;
    logic [16:0] exp_v;
    string       exp_n;

    // clock / reset block
    always #5 clk = ~clk;

    bomb_game_ctrl #(
        .DEFUSE_WIRE (2),
        .STRIKES_MAX (2),
        .BLINK_DIV   (25)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_arm     (btn_arm),
        .wire_cut    (wire_cut),
        .tmr_s1      (tmr_s1),
        .tmr_s2      (tmr_s2),
        .tmr_start   (tmr_start),
        .tmr_success (tmr_success),
        .frz_s1      (frz_s1),
        .frz_s2      (frz_s2),
        .state_o     (state_o),
        .strikes     (strikes),
        .led         (led),
        .buzzer      (buzzer)
    );

    assign act = {state_o, tmr_start, tmr_success, frz_s1, frz_s2, strikes, led, buzzer};

    function automatic string fmt(input logic [16:0] v);
        return $sformatf("st=%0d start=%0b succ=%0b frz=%h/%h stk=%0d led=%0b buz=%0b",
                         v[16:14], v[13], v[12], v[11:8], v[7:4], v[3:2], v[1], v[0]);
    endfunction

    // driver tasks
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string nm, input logic [2:0] st, input logic start,
                              input logic succ, input logic [3:0] f1, input logic [3:0] f2,
                              input logic [1:0] stk, input logic l, input logic b);
        exp_q.push_back({st, start, succ, f1, f2, stk, l, b});
        name_q.push_back(nm);
    endtask

    // scoreboard monitor: compares every pending expectation at the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            exp_n = name_q.pop_front();
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL %s: got %s, want %s", exp_n, fmt(act), fmt(exp_v));
            end
        end
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst      = 1'b0;
        btn_arm  = 1'b0;
        wire_cut = 4'b0000;
        tmr_s1   = 4'd0;
        tmr_s2   = 4'd0;
        tick(2);
        expect_out("reset", ST_IDLE, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        expect_out("idle_after_reset", ST_IDLE, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0);

        // Defuse with the correct wire while the timer shows 1,4
        tmr_s1 = 4'd1; tmr_s2 = 4'd4; btn_arm = 1'b1;
        tick();
        expect_out("a_armed", ST_ARMED, 1, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        btn_arm = 1'b0; wire_cut = 4'b0100;
        tick();
        expect_out("a_defused", ST_DEFUSED, 0, 1, 4'h1, 4'h4, 2'd0, 1, 0);
        tick(24);
        expect_out("a_led_hold1", ST_DEFUSED, 0, 1, 4'h1, 4'h4, 2'd0, 1, 0);
        tick();
        expect_out("a_led_low", ST_DEFUSED, 0, 1, 4'h1, 4'h4, 2'd0, 0, 0);
        tick(24);
        expect_out("a_led_hold0", ST_DEFUSED, 0, 1, 4'h1, 4'h4, 2'd0, 0, 0);
        tick();
        expect_out("a_led_high", ST_DEFUSED, 0, 1, 4'h1, 4'h4, 2'd0, 1, 0);
        tmr_s1 = 4'd0; tmr_s2 = 4'd9;
        tick();
        expect_out("a_frz_hold", ST_DEFUSED, 0, 1, 4'h1, 4'h4, 2'd0, 1, 0);
        btn_arm = 1'b1;
        tick();
        expect_out("a_to_idle", ST_IDLE, 0, 0, 4'h1, 4'h4, 2'd0, 0, 0);
        btn_arm = 1'b0; wire_cut = 4'b0000;
        tick();

        // Two wrong cuts detonate; a second arm press while ARMED is ignored
        tmr_s1 = 4'd3; tmr_s2 = 4'd2; btn_arm = 1'b1;
        tick();
        expect_out("b_armed", ST_ARMED, 1, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        btn_arm = 1'b0;
        tick();
        btn_arm = 1'b1;
        tick();
        expect_out("b_arm_ignored", ST_ARMED, 1, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        btn_arm = 1'b0; wire_cut = 4'b0001;
        tick();
        expect_out("b_strike1", ST_ARMED, 1, 0, 4'h0, 4'h0, 2'd1, 0, 0);
        tick();
        expect_out("b_strike1_hold", ST_ARMED, 1, 0, 4'h0, 4'h0, 2'd1, 0, 0);
        tmr_s1 = 4'd7; wire_cut = 4'b1001;
        tick();
        expect_out("b_exploded", ST_EXPLODED, 0, 0, 4'h7, 4'h2, 2'd2, 0, 1);
        tick(24);
        expect_out("b_buz_hold1", ST_EXPLODED, 0, 0, 4'h7, 4'h2, 2'd2, 0, 1);
        tick();
        expect_out("b_buz_low", ST_EXPLODED, 0, 0, 4'h7, 4'h2, 2'd2, 0, 0);
        btn_arm = 1'b1;
        tick();
        expect_out("b_to_idle", ST_IDLE, 0, 0, 4'h7, 4'h2, 2'd2, 0, 0);
        btn_arm = 1'b0; wire_cut = 4'b0000;
        tick();

        // Timer expiry, alone and with a simultaneous correct cut
        tmr_s1 = 4'd5; tmr_s2 = 4'd5; btn_arm = 1'b1;
        tick();
        expect_out("c_armed", ST_ARMED, 1, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        btn_arm = 1'b0; tmr_s1 = 4'hF; tmr_s2 = 4'hF;
        tick();
        expect_out("c_expired", ST_EXPLODED, 0, 0, 4'h0, 4'h0, 2'd0, 0, 1);
        btn_arm = 1'b1;
        tick();
        expect_out("c_to_idle", ST_IDLE, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        btn_arm = 1'b0; tmr_s1 = 4'd5; tmr_s2 = 4'd5;
        tick();
        btn_arm = 1'b1;
        tick();
        expect_out("c_armed2", ST_ARMED, 1, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        btn_arm = 1'b0;
        tick();
        tmr_s1 = 4'hF; tmr_s2 = 4'hF; wire_cut = 4'b0100;
        tick();
        expect_out("c_expiry_beats_defuse", ST_EXPLODED, 0, 0, 4'h0, 4'h0, 2'd0, 0, 1);
        btn_arm = 1'b1;
        tick();
        btn_arm = 1'b0; wire_cut = 4'b0000; tmr_s1 = 4'd0; tmr_s2 = 4'd0;
        tick();

        // Arm attempt with a wire already cut
        wire_cut = 4'b0010; btn_arm = 1'b1;
        tick();
        expect_out("d_arm_err", ST_ARM_ERR, 0, 0, 4'h0, 4'h0, 2'd0, 0, 1);
        btn_arm = 1'b0;
        tick();
        expect_out("d_arm_err_hold", ST_ARM_ERR, 0, 0, 4'h0, 4'h0, 2'd0, 0, 1);
        tick(23);
        expect_out("d_buz_hold1", ST_ARM_ERR, 0, 0, 4'h0, 4'h0, 2'd0, 0, 1);
        tick();
        expect_out("d_buz_low", ST_ARM_ERR, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        wire_cut = 4'b0000;
        tick();
        expect_out("d_restored", ST_IDLE, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0);

        // Wrong and correct wire cut in the same cycle
        tmr_s1 = 4'd2; tmr_s2 = 4'd6; btn_arm = 1'b1;
        tick();
        expect_out("e_armed", ST_ARMED, 1, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        btn_arm = 1'b0;
        tick();
        wire_cut = 4'b0110;
        tick();
        expect_out("e_double_cut", ST_DEFUSED, 0, 1, 4'h2, 4'h6, 2'd1, 1, 0);
        btn_arm = 1'b1;
        tick();
        expect_out("e_to_idle", ST_IDLE, 0, 0, 4'h2, 4'h6, 2'd1, 0, 0);
        btn_arm = 1'b0; wire_cut = 4'b0000;
        tick();

        // Reset mid-game with a wire cut across the reset
        btn_arm = 1'b1;
        tick();
        expect_out("f_armed", ST_ARMED, 1, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        btn_arm = 1'b0;
        tick();
        rst = 1'b0; wire_cut = 4'b0001;
        expect_out("f_async_reset", ST_IDLE, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        tick();
        expect_out("f_in_reset", ST_IDLE, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        rst = 1'b1;
        tick();
        expect_out("f_released", ST_IDLE, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        tick();
        expect_out("f_no_strike", ST_IDLE, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0);
        btn_arm = 1'b1;
        tick();
        expect_out("f_arm_err", ST_ARM_ERR, 0, 0, 4'h0, 4'h0, 2'd0, 0, 1);
        btn_arm = 1'b0; wire_cut = 4'b0000;
        tick();
        expect_out("f_idle", ST_IDLE, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0);

        // final report: drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bomb_game_ctrl.md
BOMB_GAME_CTRL -- requirements
Module: bomb_game_ctrl

Interface
REQ-001 Parameter DEFUSE_WIRE, default 2, index (0..3) of the single correct wire.
REQ-002 Parameter STRIKES_MAX, default 2, wrong cuts that cause detonation (1..3).
REQ-003 Parameter BLINK_DIV, default 25, clk cycles per half-period of led/buzzer toggling (>=1).
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 btn_arm  in  1  arm request, synchronous level; acts on its rising edge only.
REQ-007 wire_cut  in  4  one bit per wire, 1 = cut, synchronous levels.
REQ-008 tmr_s1  in  4  countdown units digit from timer.
REQ-009 tmr_s2  in  4  countdown tens digit from timer; both digits 4'hF = timer expired.
REQ-010 tmr_start  out  1  enables timer countdown.
REQ-011 tmr_success  out  1  defuse indication to timer.
REQ-012 frz_s1, frz_s2  out  4 each  digits latched at game end.
REQ-013 state_o  out  3  current state encoding.
REQ-014 strikes  out  2  wrong cuts counted this game.
REQ-015 led  out  1  defused indicator; buzzer  out  1  detonation indicator.

Function
REQ-016 States: IDLE=0, ARM_ERR=1, ARMED=2, DEFUSED=3, EXPLODED=4; state_o equals the encoding, registered.
REQ-017 btn_arm and wire_cut registered once; edges = current & ~previous registered value.
REQ-018 IDLE: btn_arm rising edge with wire_cut==0 -> ARMED; with wire_cut!=0 -> ARM_ERR.
REQ-019 ARM_ERR: returns to IDLE in the first cycle wire_cut==0; buzzer = blink waveform while in ARM_ERR.
REQ-020 On entry to ARMED: strikes cleared to 0, blink counter cleared.
REQ-021 ARMED: tmr_start=1; all other states tmr_start=0.
REQ-022 ARMED, rising edge on bit DEFUSE_WIRE -> DEFUSED next cycle; frz_s1/frz_s2 latch tmr_s1/tmr_s2 of that cycle.
REQ-023 ARMED, rising edge on any other bit -> strikes+1 (saturating at 3); if new count >= STRIKES_MAX -> EXPLODED.
REQ-024 Multiple wire edges in one cycle: if DEFUSE_WIRE edge present, strikes incremented by 1 only if another bit also rose; evaluation order: expiry, then strikes, then defuse.
REQ-025 ARMED, tmr_s1==4'hF and tmr_s2==4'hF -> EXPLODED, takes priority over any same-cycle cut; frz digits latch 0,0.
REQ-026 Strike-triggered EXPLODED latches current tmr digits into frz_s1/frz_s2.
REQ-027 Wire edges re-cutting already-cut wires impossible (levels); falling edges (wire restored) ignored.
REQ-028 DEFUSED: tmr_success=1, led = blink waveform, buzzer=0; EXPLODED: buzzer = blink waveform, led=0, tmr_success=0.
REQ-029 Blink waveform: counter 0..BLINK_DIV-1, output toggles on wrap, starts at 1 on state entry.
REQ-030 DEFUSED/EXPLODED: btn_arm rising edge -> IDLE; frz digits, strikes hold until next ARMED entry.
REQ-031 btn_arm in ARMED ignored.

Reset
REQ-032 rst low: state IDLE, tmr_start=0, tmr_success=0, frz_s1=frz_s2=0, strikes=0, led=0, buzzer=0, edge registers 0, blink counter 0.
REQ-033 Reset mid-game overrides immediately; wires cut during reset and still cut afterwards produce no edge after release.

Structure
REQ-034 Package bomb_pkg holds state encodings, digit-expired constant 4'hF, wire count 4.
REQ-035 One sub-module bomb_blink (counter + toggle, clear input) shared by led and buzzer paths.

Verification
REQ-036 Arm with wires intact, cut wire 2 when timer shows 1,4 -> DEFUSED, frz=1/4, tmr_success=1, led toggles every 25 cycles.
REQ-037 Arm, cut wire 0 then wire 3 -> strikes 1 then 2, EXPLODED on second cut, buzzer toggling, tmr_start=0.
REQ-038 Arm, no cuts, drive tmr digits F,F -> EXPLODED next cycle, frz=0/0; same-cycle cut of wire 2 still gives EXPLODED.
REQ-039 btn_arm with wire 1 cut -> ARM_ERR, buzzer blinking; restore wire -> IDLE next cycle.
REQ-040 Wires 1 and 2 cut same cycle in ARMED -> strikes=1, DEFUSED.
REQ-041 Assert rst during ARMED with wire 0 cut; release -> IDLE, all outputs at reset values, no strike.
